// File: rtl/ib_fifo_sub.sv
// ib_fifo_sub
// Per-port input buffer for the mesh router. Stores up to DEPTH flits in
// arrival order and presents the oldest one (show-ahead) to the
// route-computation stage. The current occupancy is exported as a pressure
// value, which neighbouring routers use for adaptive W/N selection.
//
// Ports:
//   ib_clk        sole clock; all state changes on its rising edge
//   rst           synchronous, active-high reset
//   data_in       flit from the link (DATASIZE bits)
//   valid_in      data_in carries a flit this cycle
//   ready_out     buffer can accept a flit this cycle
//   data_out      head flit toward route computation (all-zero when empty)
//   valid_out     data_out holds a real flit
//   rc_ready      route computation consumes data_out this cycle
//   pressure_out  current occupancy, 0..DEPTH
//   overflow_err  sticky flag, set by a write attempt while full
module ib_fifo_sub #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                ib_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                overflow_err
);

  localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic [WIDTH:0]      count;
  logic                push;
  logic                pop;
  logic                full;

  // Handshake flags are decoded from the registered count only, so ready_out
  // and pressure_out never depend combinationally on rc_ready and only move
  // at clock edges.
  always_comb begin
    full      = (count == FULL_COUNT);
    ready_out = ~full;
    valid_out = (count != '0);
    push      = valid_in & ready_out;
    pop       = valid_out & rc_ready;
    // Forced to zero when empty so stale memory contents never leak out.
    data_out  = valid_out ? mem[rd_ptr] : '0;
    pressure_out = count;
  end

  // Flit storage carries no reset; an empty buffer masks its contents.
  always_ff @(posedge ib_clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the sticky error flag. Reset takes priority
  // over any push or pop in the same cycle. A pop while full frees a slot
  // only from the next cycle on, so a simultaneous write attempt is still
  // dropped and flagged.
  always_ff @(posedge ib_clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (WIDTH+1)'(1);
        2'b01:   count <= count - (WIDTH+1)'(1);
        default: count <= count;
      endcase
      if (valid_in && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ib_fifo_sub.sv
// tb_ib_fifo_sub
// Self-checking bench for ib_fifo_sub: a table of single-cycle vectors
// covering reset, single flit, fill, overflow and drain, followed by
// hand-written sequences for full-with-pop, wrap-around streaming and
// mid-stream reset.
module tb_ib_fifo_sub;

  logic        ib_clk;
  logic        rst;
  logic [39:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [39:0] data_out;
  logic        valid_out;
  logic        rc_ready;
  logic [3:0]  pressure_out;
  logic        overflow_err;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic        rst;
    logic        vin;
    logic [39:0] din;
    logic        rc;
    logic        exp_valid;
    logic        exp_ready;
    logic [39:0] exp_dout;
    logic [3:0]  exp_press;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  logic [39:0] model[$];

  ib_fifo_sub #(.DEPTH(8), .WIDTH(3), .DATASIZE(40)) dut (
    .ib_clk       (ib_clk),
    .rst          (rst),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .rc_ready     (rc_ready),
    .pressure_out (pressure_out),
    .overflow_err (overflow_err)
  );

  initial ib_clk = 1'b0;
  always #5 ib_clk = ~ib_clk;

  // Distinct flit for index i, touching every field.
  function automatic logic [39:0] flit(input int i);
    return {4'(i), 4'(i + 1), 8'(i), 22'(i * 3 + 1), 2'(i)};
  endfunction

  // Drive inputs, let one rising edge pass, then settle just after it.
  task automatic applyStimulus(input logic r, input logic vin,
                               input logic [39:0] din, input logic rc);
    rst      = r;
    valid_in = vin;
    data_in  = din;
    rc_ready = rc;
    @(posedge ib_clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [39:0] act,
                          input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic er,
                             input logic [39:0] ed, input logic [3:0] ep,
                             input logic eo);
    checkOne({name, ".valid_out"},    40'(valid_out),    40'(ev));
    checkOne({name, ".ready_out"},    40'(ready_out),    40'(er));
    checkOne({name, ".data_out"},     data_out,          ed);
    checkOne({name, ".pressure_out"}, 40'(pressure_out), 40'(ep));
    checkOne({name, ".overflow_err"}, 40'(overflow_err), 40'(eo));
  endtask

  function automatic vec_t mk(string n, logic r, logic vin, logic [39:0] din,
                              logic rc, logic ev, logic er, logic [39:0] ed,
                              logic [3:0] ep, logic eo);
    vec_t v;
    v.name = n; v.rst = r; v.vin = vin; v.din = din; v.rc = rc;
    v.exp_valid = ev; v.exp_ready = er; v.exp_dout = ed;
    v.exp_press = ep; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 40'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 40'h0, 1'b0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    rc_ready = 1'b0;

    // Vector table: reset, single flit, fill, overflow, drain.
    vecs.push_back(mk("rst0", 1, 0, 40'h0, 0, 0, 1, 40'h0, 0, 0));
    vecs.push_back(mk("rst1", 1, 0, 40'h0, 0, 0, 1, 40'h0, 0, 0));
    vecs.push_back(mk("idle_empty", 0, 0, 40'h0, 1, 0, 1, 40'h0, 0, 0));
    vecs.push_back(mk("single_push", 0, 1, 40'h1_2_05_ABCDE_1, 0,
                      1, 1, 40'h1_2_05_ABCDE_1, 1, 0));
    vecs.push_back(mk("single_pop", 0, 0, 40'h0, 1, 0, 1, 40'h0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk($sformatf("fill%0d", k), 0, 1, flit(k - 1), 0,
                        1, (k != 8), flit(0), 4'(k), 0));
    vecs.push_back(mk("overflow", 0, 1, flit(8), 0, 1, 0, flit(0), 8, 1));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk($sformatf("drain%0d", j), 0, 0, 40'h0, 1,
                        (j < 8), 1, (j < 8) ? flit(j) : 40'h0, 4'(8 - j), 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].rc);
      checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_ready,
                  vecs[i].exp_dout, vecs[i].exp_press, vecs[i].exp_ovf);
    end

    // Full with simultaneous write attempt and pop: the pop proceeds, the
    // write is dropped, and a slot is free the next cycle.
    $display("[TB] full with simultaneous pop");
    resetDut();
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, flit(20 + k), 1'b0);
    applyStimulus(1'b0, 1'b1, flit(99), 1'b1);
    checkOutput("full_pop", 1, 1, flit(21), 7, 1);
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(1'b0, 1'b0, 40'h0, 1'b1);
      checkOne($sformatf("full_pop_drain%0d", j), data_out,
               (j < 7) ? flit(21 + j) : 40'h0);
    end

    // Wrap-around streaming: preload 3, then 20 cycles of push + pop.
    $display("[TB] wrap-around streaming");
    resetDut();
    model.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, flit(100 + k), 1'b0);
      model.push_back(flit(100 + k));
    end
    for (int i = 0; i < 20; i++) begin
      checkOne($sformatf("stream_head%0d", i), data_out, model[0]);
      applyStimulus(1'b0, 1'b1, flit(103 + i), 1'b1);
      void'(model.pop_front());
      model.push_back(flit(103 + i));
      checkOne($sformatf("stream_press%0d", i), 40'(pressure_out), 40'd3);
      checkOne($sformatf("stream_valid%0d", i), 40'(valid_out), 40'd1);
    end
    for (int j = 0; j < 3; j++) begin
      checkOne($sformatf("stream_tail%0d", j), data_out, model[0]);
      applyStimulus(1'b0, 1'b0, 40'h0, 1'b1);
      void'(model.pop_front());
    end
    checkOutput("stream_empty", 0, 1, 40'h0, 0, 0);

    // Reset mid-operation with an overflow already latched.
    $display("[TB] reset mid-operation");
    resetDut();
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, flit(40 + k), 1'b0);
    applyStimulus(1'b0, 1'b1, flit(50), 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 40'h0, 1'b1);
    checkOutput("pre_reset", 1, 1, flit(43), 5, 1);
    applyStimulus(1'b1, 1'b1, flit(60), 1'b1);
    checkOutput("mid_reset", 0, 1, 40'h0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 40'h0, 1'b1);
      checkOutput($sformatf("post_reset%0d", k), 0, 1, 40'h0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ib_fifo_sub.md
# ib_fifo_sub

Per-port input buffer for the mesh router. It sits directly upstream of the route-computation stage. It accepts 40-bit flits from the link, stores up to DEPTH of them in order, and presents the head flit with a valid flag to route computation. It also exports its occupancy as a pressure value that neighbouring routers use for adaptive W/N selection.

## Interface
- DEPTH, 8: flit slots; must be a power of two, equal to 2**WIDTH.
- WIDTH, 3: pointer width; occupancy and pressure are WIDTH+1 bits.
- DATASIZE, 40: flit width. Fields: src [39:36], dst [35:32], timestamp [31:24], data [23:2], type [1:0].

Ports:
- ib_clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATASIZE  flit from link.
- valid_in  in  1  flit on data_in is valid this cycle.
- ready_out  out  1  buffer can accept a flit this cycle.
- data_out  out  DATASIZE  head flit, toward route computation.
- valid_out  out  1  data_out holds a real flit.
- rc_ready  in  1  route computation consumes data_out this cycle.
- pressure_out  out  WIDTH+1  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky; set on a write attempt while full.

## Operation
- Storage: DEPTH x DATASIZE register array, write pointer wr_ptr, read pointer rd_ptr (both WIDTH bits, wrap modulo DEPTH), count (WIDTH+1 bits).
- push = valid_in & ready_out. pop = valid_out & rc_ready.
- ready_out = (count != DEPTH), decoded from registered count only, with no combinational path from rc_ready.
- valid_out = (count != 0). data_out = mem[rd_ptr] (show-ahead head).
  - When empty, data_out is forced to all-zero so route computation sees dst 0 with valid 0.
- On push: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- count rules:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full and rc_ready=1: the pop proceeds. ready_out is still 0 that cycle, so there is no push. Next cycle count = DEPTH-1 and ready_out = 1.
- Empty and valid_in=1: push occurs and there is no pop. The flit appears on data_out the next cycle.
- Empty and rc_ready=1: there is no pop, and pointers are unchanged.
- valid_in=1 while full: the flit is dropped and state is unchanged. overflow_err <= 1 and holds until rst.
- pressure_out = count, registered (no extra stage).
- Flit contents pass through unmodified; the buffer does not interpret fields.
- Reset:
  - wr_ptr, rd_ptr and count go to 0.
  - overflow_err goes to 0.
  - Memory contents are don't-care but unobservable, because data_out is forced to 0 while empty.
  - Reset mid-stream discards all stored flits at that edge.
  - rst dominates push and pop in the same cycle.

## Timing
- Reset values:
  - valid_out = 0, data_out = 0.
  - ready_out = 1.
  - pressure_out = 0, overflow_err = 0.
- Write-to-head latency: a flit pushed at edge N is visible on data_out/valid_out after edge N, when the buffer was empty.
- Throughput: 1 push and 1 pop per cycle sustained, at any occupancy 1..DEPTH-1.
- Route computation samples data_out/valid_out on its own edge when rc_ready=1. The pop is counted at that same edge, so each flit is delivered exactly once.
- pressure_out and ready_out change only at ib_clk edges. Both are glitch-free to neighbouring routers.

## Test plan
- Reset and empty:
  - Stimulus: rst for 2 cycles, then idle with rc_ready=1.
  - Required: valid_out=0, data_out=0, ready_out=1, pressure_out=0, overflow_err=0.
- Single flit:
  - Stimulus: push 40'h1_2_05_ABCDE_1 into an empty buffer with rc_ready=0.
  - Required: next cycle valid_out=1, data_out=that flit, pressure_out=1.
  - Then assert rc_ready for 1 cycle. Required: valid_out=0, pressure_out=0.
- Fill and overflow:
  - Stimulus: push 8 flits (payload 0..7) with rc_ready=0.
  - Required: ready_out=0, pressure_out=8.
  - Then a 9th valid_in. Required: overflow_err=1, pressure_out stays 8.
  - Then drain. Required: data_out order is 0..7, and the 9th flit never appears.
- Full with simultaneous pop:
  - Stimulus: buffer full, valid_in=1 and rc_ready=1 for 1 cycle.
  - Required: pressure_out=7, no overflow increment of count, ready_out=1 next cycle.
- Wrap-around streaming:
  - Stimulus: 20 flits at 1 push + 1 pop per cycle, after pre-loading 3.
  - Required: pressure_out holds 3, output order matches input order across pointer wrap, no gaps in valid_out.
- Reset mid-operation:
  - Stimulus: 5 flits stored, rst pulsed with valid_in=1 and rc_ready=1.
  - Required: next cycle pressure_out=0, valid_out=0, overflow_err=0.
  - No stale flit is emitted after reset release.
